// File: rtl/uart_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl_pkg
// Purpose  : Shared definitions for the UART-to-ALU sequencer: FSM state
//            encoding, ALU opcode values (also used by the ALU) and a helper
//            that sizes the inter-byte timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_alu_ctrl_pkg;

  // Sequencer states, 3-bit binary encoding
  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_TX = 3'd4
  } ctrl_state_t;

  // ALU opcode values; any other opcode makes the ALU return zero
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_NOR = 8'h27;

  // Width of a counter that has to hold the value 0..limit, never below 1 bit
  function automatic int unsigned timer_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_alu_ctrl_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl_frame_timer
// Purpose  : Inter-byte watchdog for the frame collector. Counts one per clock
//            while enabled and not cleared, saturating at TIMEOUT_CYCLES.
//            o_expired is high in the cycle whose closing edge would bring the
//            count to TIMEOUT_CYCLES, so the owner can act on that same edge.
//            TIMEOUT_CYCLES = 0 removes the counter and never expires.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl_frame_timer
  import uart_alu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_timer_off
      // Timeout disabled: inputs are intentionally ignored
      logic w_unused;
      assign w_unused  = ^{clk, reset, i_clear, i_enable};
      assign o_expired = 1'b0;
    end else begin : g_timer_on
      localparam int unsigned TW = timer_width(TIMEOUT_CYCLES);
      localparam logic [TW-1:0] C_LIMIT = TW'(TIMEOUT_CYCLES);
      localparam logic [TW-1:0] C_LAST  = TW'(TIMEOUT_CYCLES - 1);

      logic [TW-1:0] r_count;

      // Idle-cycle counter: cleared on request, saturates instead of wrapping
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_count <= '0;
        end else if (i_clear) begin
          r_count <= '0;
        end else if (i_enable && (r_count != C_LIMIT)) begin
          r_count <= r_count + 1'b1;
        end
      end

      // A clear in the same cycle (a byte arriving) suppresses expiry
      assign o_expired = i_enable && !i_clear && (r_count == C_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl
// Purpose  : Sequencer between UART RX/TX and the combinational ALU. Collects
//            operand A, operand B and opcode from RX, holds them registered
//            on the ALU inputs, gives the ALU one cycle to settle, then hands
//            the result to TX as a single byte. Aborts a partial frame on an
//            inter-byte timeout and drops bytes that arrive while a result
//            is being produced or sent, flagging both with frame_err.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OP_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  tx_done,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  frame_err
);

  ctrl_state_t r_state;

  logic w_timer_en;
  logic w_timer_clr;
  logic w_timer_expired;

  // The timeout only guards the gaps inside a frame (after A, after B).
  // Holding it cleared elsewhere means every entry into WAIT_B/WAIT_OP,
  // which always happens on an rx_done, starts from zero.
  assign w_timer_en  = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_timer_clr = rx_done || !w_timer_en;

  uart_alu_ctrl_frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_timer_clr),
    .i_enable  (w_timer_en),
    .o_expired (w_timer_expired)
  );

  // Frame sequencer with registered ALU operands, TX handoff and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_WAIT_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Pulsed outputs default low every cycle
      tx_start  <= 1'b0;
      frame_err <= 1'b0;

      case (r_state)
        ST_WAIT_A: begin
          if (rx_done) begin
            alu_a   <= rx_data;
            busy    <= 1'b1;
            r_state <= ST_WAIT_B;
          end
        end

        ST_WAIT_B: begin
          // A byte arriving on the expiry cycle is still accepted
          if (rx_done) begin
            alu_b   <= rx_data;
            r_state <= ST_WAIT_OP;
          end else if (w_timer_expired) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            r_state   <= ST_WAIT_A;
          end
        end

        ST_WAIT_OP: begin
          if (rx_done) begin
            alu_op  <= rx_data[OP_WIDTH-1:0];
            r_state <= ST_EXEC;
          end else if (w_timer_expired) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            r_state   <= ST_WAIT_A;
          end
        end

        ST_EXEC: begin
          // ALU inputs have been stable for a full cycle: capture and send
          tx_data  <= alu_result;
          tx_start <= 1'b1;
          r_state  <= ST_WAIT_TX;
          if (rx_done) begin
            frame_err <= 1'b1;
          end
        end

        ST_WAIT_TX: begin
          // Overrun bytes are dropped; the pending transmission is unaffected
          if (rx_done) begin
            frame_err <= 1'b1;
          end
          if (tx_done) begin
            busy    <= 1'b0;
            r_state <= ST_WAIT_A;
          end
        end

        default: begin
          busy    <= 1'b0;
          r_state <= ST_WAIT_A;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_alu_ctrl
// Purpose  : Self-checking bench for uart_alu_ctrl: table of known frames,
//            hand-written timeout / overrun / reset sequences, and random
//            frames checked against a byte-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_alu_ctrl;
  import uart_alu_ctrl_pkg::*;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       frame_err;

  int n_total = 0;
  int n_pass  = 0;

  uart_alu_ctrl #(
    .DATA_WIDTH     (8),
    .OP_WIDTH       (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .tx_done    (tx_done),
    .alu_result (alu_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: serves both as the DUT's environment and as the oracle
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  // Full frame with exact latency checks; exp is the expected TX byte
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp, input int gap, input int txd_delay);
    send_byte(a);
    check("busy_after_a", busy, 1);
    idle(gap);
    send_byte(b);
    idle(gap);
    send_byte(op);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, op);
    check("tx_start_during_exec", tx_start, 0);
    step();
    check("tx_start_pulse", tx_start, 1);
    check("tx_data", tx_data, exp);
    step();
    check("tx_start_one_cycle", tx_start, 0);
    idle(txd_delay);
    check("busy_wait_tx", busy, 1);
    pulse_tx_done();
    check("busy_after_tx_done", busy, 0);
  endtask

  // Bounded wait for a frame_err pulse; want = cycles since the last byte edge
  task automatic expect_timeout(input string name, input int want);
    int k = 0;
    while (k < 3 * TO && frame_err !== 1'b1) begin
      step();
      k++;
    end
    check(name, 64'(k), 64'(want));
    check({name, "_busy"}, busy, 0);
    step();
    check({name, "_pulse_width"}, frame_err, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] ops[9];
  logic [7:0] q[$];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
    vecs[1] = '{8'h80, 8'h02, 8'h03, 8'hE0};
    vecs[2] = '{8'h80, 8'h02, 8'h02, 8'h20};
    vecs[3] = '{8'h01, 8'h01, 8'h22, 8'h00};
    vecs[4] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
    vecs[5] = '{8'h12, 8'h34, 8'hFF, 8'h00};
    vecs[6] = '{8'hCC, 8'hAA, 8'h24, 8'h88};
    vecs[7] = '{8'hCC, 8'hAA, 8'h26, 8'h66};
    vecs[8] = '{8'hCC, 8'hAA, 8'h27, 8'h11};
    vecs[9] = '{8'h03, 8'h05, 8'h22, 8'hFE};
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR, 8'h00};

    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err}, 0);
    reset = 1'b0;
    step();
    check("idle_not_busy", busy, 0);

    // Known frames, including unknown opcode 0xFF
    for (int i = 0; i < 10; i++)
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, i % 3, i % 4);

    // tx_done outside WAIT_TX is ignored
    pulse_tx_done();
    check("tx_done_idle_ignored", busy, 0);
    send_byte(8'h09);
    pulse_tx_done();
    check("tx_done_wait_b_ignored", busy, 1);
    send_byte(8'h04);
    send_byte(OP_SUB);
    step();
    check("tx_data_after_stray_tx_done", tx_data, 8'h05);
    step();
    pulse_tx_done();

    // Timeout after operand A only, then a normal SUB frame
    send_byte(8'h11);
    expect_timeout("timeout_wait_b", TO);
    check("stale_alu_a", alu_a, 8'h11);
    run_frame(8'h01, 8'h01, OP_SUB, 8'h00, 1, 1);

    // Byte on the expiry cycle wins, then timeout in WAIT_OP
    send_byte(8'h21);
    idle(TO - 1);
    send_byte(8'h22);
    check("rx_wins_no_err", frame_err, 0);
    check("rx_wins_alu_b", alu_b, 8'h22);
    check("rx_wins_busy", busy, 1);
    expect_timeout("timeout_wait_op", TO);
    check("stale_alu_b", alu_b, 8'h22);

    // Overrun during WAIT_TX
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(OP_ADD);
    step();
    check("ovr_tx_data", tx_data, 8'h30);
    step();
    send_byte(8'h55);
    check("ovr_wait_tx_err", frame_err, 1);
    check("ovr_tx_data_kept", tx_data, 8'h30);
    check("ovr_alu_a_kept", alu_a, 8'h10);
    step();
    check("ovr_err_pulse", frame_err, 0);
    idle(5);
    check("ovr_still_busy", busy, 1);
    pulse_tx_done();
    check("ovr_release", busy, 0);

    // Overrun during EXEC: result still sent
    send_byte(8'h07);
    send_byte(8'h02);
    send_byte(OP_SUB);
    send_byte(8'h99);
    check("exec_ovr_err", frame_err, 1);
    check("exec_ovr_tx_start", tx_start, 1);
    check("exec_ovr_tx_data", tx_data, 8'h05);
    step();
    pulse_tx_done();

    // Async reset in WAIT_OP
    send_byte(8'hA1);
    send_byte(8'hB2);
    idle(2);
    reset = 1'b1;
    #1;
    check("rst_mid_wait_op", {alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err}, 0);
    #2;
    reset = 1'b0;
    step();
    check("rst_op_idle", busy, 0);

    // Async reset in WAIT_TX
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(OP_ADD);
    step();
    step();
    reset = 1'b1;
    #1;
    check("rst_mid_wait_tx", {alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err}, 0);
    #2;
    reset = 1'b0;
    step();
    run_frame(8'hF0, 8'h0F, OP_OR, 8'hFF, 0, 0);

    // Randomized frames against a byte-queue model
    for (int it = 0; it < 40; it++) begin
      int nbytes;
      logic [7:0] exp;
      q = {};
      if ($urandom_range(0, 4) == 0) begin
        nbytes = $urandom_range(1, 2);
        for (int j = 0; j < nbytes; j++) begin
          q.push_back(8'($urandom));
          send_byte(q[j]);
          if (j + 1 < nbytes) idle($urandom_range(0, 8));
        end
        expect_timeout("rand_timeout", TO);
        check("rand_timeout_alu_a", alu_a, q[0]);
      end else begin
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 8)]);
        exp = alu_ref(q[0], q[1], q[2]);
        run_frame(q[0], q[1], q[2], exp, $urandom_range(0, 8), $urandom_range(0, 5));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
